// File: rtl/cell_pos_reader.sv
// Sweeps one cell position memory (addresses 0..particle_count-1) and streams each word over valid/ready,
// absorbing in-flight reads in a credit-limited FWFT FIFO. Define CELL_READER_PID_EN to add out_pid.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic                  out_last,
`ifdef CELL_READER_PID_EN
  output logic [ADDR_WIDTH-1:0] out_pid,
`endif
  output logic                  busy,
  output logic                  done
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
`ifdef CELL_READER_PID_EN
    logic [ADDR_WIDTH-1:0] pid;
`endif
    logic                  last;
    logic [DATA_WIDTH-1:0] pos;
  } entry_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt, cnt_q, last_addr;
  logic                  issue, issue_last, push, pop, wr_en, rd_en, fifo_empty, credit_ok;
  logic [RD_LATENCY:1]   vld_pipe, last_pipe;
`ifdef CELL_READER_PID_EN
  logic [RD_LATENCY:1][ADDR_WIDTH-1:0] pid_pipe;
`endif
  entry_t                fifo_mem [FIFO_DEPTH];
  entry_t                push_entry, head;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;
  int                    inflight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Oversized counts are clamped to the memory depth rather than reading past it.
  assign last_addr = (int'(cnt_q) > PARTICLE_NUM) ? ADDR_WIDTH'(PARTICLE_NUM - 1) : cnt_q - 1'b1;

  always_comb begin
    inflight = 0;
    for (int i = 1; i <= RD_LATENCY; i++) if (vld_pipe[i]) inflight++;
  end

  // Every word already in the FIFO or still in flight holds a slot; a same-cycle pop frees one.
  assign fifo_empty = (fifo_count == '0);
  assign push       = vld_pipe[RD_LATENCY];
  assign out_valid  = !fifo_empty || push;
  assign pop        = out_valid && out_ready;
  assign credit_ok  = (int'(fifo_count) + inflight) < (FIFO_DEPTH + (pop ? 1 : 0));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (particle_count == '0) ? DONE : ISSUE;
      ISSUE: if (credit_ok) begin
        issue = 1'b1;
        if (addr_cnt == last_addr) state_nxt = DRAIN;
      end
      DRAIN: if (pop && out_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_last  = issue && (addr_cnt == last_addr);
  assign mem_rden    = issue;
  assign mem_address = issue ? addr_cnt : '0;
  assign mem_wren    = 1'b0;

  always_comb begin
    push_entry      = '0;
    push_entry.pos  = mem_q;
    push_entry.last = last_pipe[RD_LATENCY];
`ifdef CELL_READER_PID_EN
    push_entry.pid  = pid_pipe[RD_LATENCY];
`endif
  end

  // Fall-through: an arriving word is presented directly when the FIFO is empty.
  assign head     = fifo_empty ? push_entry : fifo_mem[rd_ptr];
  assign out_pos  = out_valid ? head.pos  : '0;
  assign out_last = out_valid ? head.last : 1'b0;
`ifdef CELL_READER_PID_EN
  assign out_pid  = out_valid ? head.pid  : '0;
`endif

  assign wr_en = push && !(fifo_empty && pop);
  assign rd_en = pop && !fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_cnt   <= '0;
      cnt_q      <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
`ifdef CELL_READER_PID_EN
      pid_pipe   <= '0;
`endif
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        cnt_q    <= particle_count;
        addr_cnt <= '0;
      end else if (issue) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue_last;
`ifdef CELL_READER_PID_EN
      pid_pipe[1]  <= addr_cnt;
`endif
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
`ifdef CELL_READER_PID_EN
        pid_pipe[i]  <= pid_pipe[i-1];
`endif
      end
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
